// File: rtl/sifh_peak_finder.sv
// sifh_peak_finder
// Scans the shared histogram RAM after an acquisition, one pixel at a time. For
// each pixel it reports the bin with the highest count, and it can optionally zero
// every bin it has read.
//
// Ports
//   clk, res             clock; synchronous active-high reset
//   start, clear_en      start a scan of all pixels; clear_en is latched when start is accepted
//   raddr, rEnable       RAM port B read address {pixel, bin} and read enable
//   counts               RAM port B read data, valid one cycle after rEnable
//   waddr, wEnable       RAM port A write address and write enable (clear writes)
//   newCounts            RAM port A write data, always zero
//   busy, done           scan in progress; one-cycle pulse when the scan finishes
//   res_valid, res_ready result handshake
//   res_pixel, res_bin   pixel index of the result and bin index of its maximum
//   res_peak, res_empty  maximum count; set when every bin of the pixel read zero
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing one bin read per cycle for the current pixel
// DRAIN | comparing (and clearing) the last bin of the pixel
// OUT   | holding the result until the consumer accepts it
// FIN   | one-cycle done pulse, then back to IDLE
module sifh_peak_finder #(
    parameter int NB       = 6,
    parameter int PIX_W    = 2,
    parameter int RAM_ADDR = 8,
    parameter int PEAK_MAX = 8
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                clear_en,
    output logic [RAM_ADDR-1:0] raddr,
    output logic                rEnable,
    input  logic [PEAK_MAX-1:0] counts,
    output logic [RAM_ADDR-1:0] waddr,
    output logic                wEnable,
    output logic [PEAK_MAX-1:0] newCounts,
    output logic                busy,
    output logic                done,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [PIX_W-1:0]    res_pixel,
    output logic [NB-1:0]       res_bin,
    output logic [PEAK_MAX-1:0] res_peak,
    output logic                res_empty
);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, OUT, FIN} state_t;

    localparam logic [NB-1:0]    BIN_LAST = '1;
    localparam logic [PIX_W-1:0] PIX_LAST = '1;

    state_t state, state_nxt;

    logic [PIX_W-1:0]    pixel;
    logic [NB-1:0]       bin;
    logic                clr;
    logic                cmp_valid;
    logic                cmp_first;
    logic [NB-1:0]       cmp_bin;
    logic [PEAK_MAX-1:0] max_q, max_nxt;
    logic [NB-1:0]       max_bin_q, max_bin_nxt;
    logic                wen_q;
    logic [RAM_ADDR-1:0] waddr_q;

    assign raddr     = {pixel, bin};
    assign waddr     = waddr_q;
    assign wEnable   = wen_q;
    assign newCounts = '0;

    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rEnable   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                rEnable = 1'b1;
                busy    = 1'b1;
                if (bin == BIN_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_nxt = (pixel == PIX_LAST) ? FIN : SCAN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data returns one cycle after the address. The first bin of a pixel
    // always loads; later bins win only when strictly greater, so ties keep the lower bin.
    always_comb begin
        max_nxt     = max_q;
        max_bin_nxt = max_bin_q;
        if (cmp_valid && (cmp_first || counts > max_q)) begin
            max_nxt     = counts;
            max_bin_nxt = cmp_bin;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pixel     <= '0;
            bin       <= '0;
            clr       <= 1'b0;
            cmp_valid <= 1'b0;
            cmp_first <= 1'b0;
            cmp_bin   <= '0;
            max_q     <= '0;
            max_bin_q <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            res_pixel <= '0;
            res_bin   <= '0;
            res_peak  <= '0;
            res_empty <= 1'b0;
        end else begin
            cmp_valid <= rEnable;
            cmp_first <= (bin == '0);
            cmp_bin   <= bin;
            max_q     <= max_nxt;
            max_bin_q <= max_bin_nxt;
            // The clear write trails the read by one cycle, so it never hits the address being read.
            wen_q     <= rEnable & clr;
            waddr_q   <= raddr;

            if (state == IDLE && start) begin
                clr   <= clear_en;
                pixel <= '0;
                bin   <= '0;
            end
            if (state == SCAN) bin <= bin + 1'b1;
            // Result registers hold until the next pixel's result, independent of the running max.
            if (state == DRAIN) begin
                res_pixel <= pixel;
                res_bin   <= max_bin_nxt;
                res_peak  <= max_nxt;
                res_empty <= (max_nxt == '0);
            end
            if (state == OUT && res_ready && pixel != PIX_LAST) begin
                pixel <= pixel + 1'b1;
                bin   <= '0;
            end
        end
    end

endmodule
